// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the program-memory loader.
// Holds the loader state encoding and the ROM geometry defaults.
package prog_mem_pkg;

  localparam int DEPTH_WORDS_DEF = 8192;
  localparam int WORD_ADDR_W     = 30;
  localparam int DATA_W          = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RB_RUN   = 3'd2,
    ST_RB_DRAIN = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/rb_hold_reg.sv
// One-entry skid register that parks a readback word while the out FIFO is full.
module rb_hold_reg
  import prog_mem_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic         unload,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid
);

  logic [W-1:0] data_r;
  logic         valid_r;

  // Skid entry: capture on load, release on unload, drop on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= {W{1'b0}};
      valid_r <= 1'b0;
    end else if (clr) begin
      data_r  <= data_r;
      valid_r <= 1'b0;
    end else if (load) begin
      data_r  <= din;
      valid_r <= 1'b1;
    end else if (unload) begin
      data_r  <= data_r;
      valid_r <= 1'b0;
    end else begin
      data_r  <= data_r;
      valid_r <= valid_r;
    end
  end

  assign dout  = data_r;
  assign valid = valid_r;

endmodule

// File: rtl/prog_mem_loader.sv
// Host loader for the core program ROM: load from pipe-in, read back to pipe-out,
// and share the single ROM port with the core flash interface.
module prog_mem_loader
  import prog_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int CNT_W       = $clog2(DEPTH_WORDS) + 1
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic                   prog_mode,
  input  logic                   cmd_load,
  input  logic                   cmd_readback,
  input  logic                   in_empty,
  input  logic [DATA_W-1:0]      in_dout,
  output logic                   in_rd_en,
  input  logic                   out_full,
  output logic [DATA_W-1:0]      out_din,
  output logic                   out_wr_en,
  input  logic                   flash_men,
  input  logic [31:0]            flash_maddr,
  input  logic [DATA_W-1:0]      flash_mdin,
  input  logic [3:0]             flash_mwe,
  output logic [DATA_W-1:0]      flash_mdout,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [WORD_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]      mem_din,
  input  logic [DATA_W-1:0]      mem_dout,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [CNT_W-1:0]       word_count
);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DEPTH_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);

  state_t              state_r, state_s;
  logic                cmd_load_q_r, cmd_rb_q_r;
  logic                pend_r, pend_s;
  logic [CNT_W-1:0]    word_count_r;
  logic                overflow_r, busy_r, done_r;
  logic                cnt_clr_s, cnt_inc_s, ovf_clr_s, ovf_set_s;
  logic                hold_clr_s, hold_load_s, hold_unload_s, hold_valid_s;
  logic [DATA_W-1:0]   hold_data_s;
  logic                fsm_mem_en_s, fsm_mem_we_s;
  logic [WORD_ADDR_W-1:0] fsm_mem_addr_s;
  logic [DATA_W-1:0]   fsm_mem_din_s, out_din_s;
  logic                in_rd_en_s, out_wr_en_s;
  logic                load_rise_s, load_fall_s, rb_rise_s, abort_s;
  logic                unused_s;

  assign load_rise_s = cmd_load & ~cmd_load_q_r;
  assign load_fall_s = ~cmd_load & cmd_load_q_r;
  assign rb_rise_s   = cmd_readback & ~cmd_rb_q_r;
  assign abort_s     = ~prog_mode & ((state_r == ST_LOAD) | (state_r == ST_RB_RUN) |
                                     (state_r == ST_RB_DRAIN));
  assign unused_s    = ^flash_maddr[1:0];

  rb_hold_reg #(.W(DATA_W)) u_hold (
    .clk    (CLK),
    .rst_n  (RESETn),
    .clr    (hold_clr_s),
    .load   (hold_load_s),
    .unload (hold_unload_s),
    .din    (mem_dout),
    .dout   (hold_data_s),
    .valid  (hold_valid_s)
  );

  // Next-state and FSM-side ROM/FIFO controls.
  always_comb begin
    state_s        = state_r;
    pend_s         = 1'b0;
    cnt_clr_s      = 1'b0;
    cnt_inc_s      = 1'b0;
    ovf_clr_s      = 1'b0;
    ovf_set_s      = 1'b0;
    hold_clr_s     = 1'b0;
    hold_load_s    = 1'b0;
    hold_unload_s  = 1'b0;
    fsm_mem_en_s   = 1'b0;
    fsm_mem_we_s   = 1'b0;
    fsm_mem_addr_s = WORD_ADDR_W'(word_count_r);
    fsm_mem_din_s  = in_dout;
    in_rd_en_s     = 1'b0;
    out_wr_en_s    = 1'b0;
    out_din_s      = {DATA_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (prog_mode && load_rise_s) begin
          state_s   = ST_LOAD;
          cnt_clr_s = 1'b1;
          ovf_clr_s = 1'b1;
        end else if (prog_mode && rb_rise_s) begin
          state_s   = ST_RB_RUN;
          cnt_clr_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort_s) begin
          state_s    = ST_IDLE;
          cnt_clr_s  = 1'b1;
          hold_clr_s = 1'b1;
        end else begin
          if (!in_empty) begin
            in_rd_en_s = 1'b1;
            if (word_count_r < DEPTH_CNT) begin
              fsm_mem_en_s = 1'b1;
              fsm_mem_we_s = 1'b1;
              cnt_inc_s    = 1'b1;
            end else begin
              ovf_set_s = 1'b1;
            end
          end else begin
            in_rd_en_s = 1'b0;
          end
          if (load_fall_s) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_LOAD;
          end
        end
      end
      ST_RB_RUN, ST_RB_DRAIN: begin
        if (abort_s) begin
          state_s    = ST_IDLE;
          cnt_clr_s  = 1'b1;
          hold_clr_s = 1'b1;
        end else begin
          // A word issued last cycle and a parked word never coexist.
          if (pend_r) begin
            if (!out_full) begin
              out_wr_en_s = 1'b1;
              out_din_s   = mem_dout;
            end else begin
              hold_load_s = 1'b1;
            end
          end else if (hold_valid_s && !out_full) begin
            out_wr_en_s   = 1'b1;
            out_din_s     = hold_data_s;
            hold_unload_s = 1'b1;
          end else begin
            out_wr_en_s = 1'b0;
          end
          if ((state_r == ST_RB_RUN) && !out_full && !hold_valid_s &&
              (word_count_r < DEPTH_CNT)) begin
            fsm_mem_en_s = 1'b1;
            cnt_inc_s    = 1'b1;
            pend_s       = 1'b1;
            if (word_count_r == LAST_CNT) begin
              state_s = ST_RB_DRAIN;
            end else begin
              state_s = ST_RB_RUN;
            end
          end else if ((state_r == ST_RB_DRAIN) && !pend_r && !hold_valid_s) begin
            state_s = ST_DONE;
          end else begin
            state_s = state_r;
          end
        end
      end
      ST_DONE: begin
        if (!prog_mode && !cmd_load && !cmd_readback) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        cnt_clr_s  = 1'b1;
        hold_clr_s = 1'b1;
      end
    endcase
  end

  // State, command edge history, counter and status registers.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_r      <= ST_IDLE;
      cmd_load_q_r <= 1'b0;
      cmd_rb_q_r   <= 1'b0;
      pend_r       <= 1'b0;
      word_count_r <= {CNT_W{1'b0}};
      overflow_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      cmd_load_q_r <= cmd_load;
      cmd_rb_q_r   <= cmd_readback;
      pend_r       <= pend_s;
      if (cnt_clr_s) begin
        word_count_r <= {CNT_W{1'b0}};
      end else if (cnt_inc_s) begin
        word_count_r <= word_count_r + CNT_ONE;
      end else begin
        word_count_r <= word_count_r;
      end
      if (ovf_clr_s) begin
        overflow_r <= 1'b0;
      end else if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
      busy_r <= (state_s == ST_LOAD) | (state_s == ST_RB_RUN) | (state_s == ST_RB_DRAIN);
      done_r <= (state_s == ST_DONE);
    end
  end

  assign mem_en      = prog_mode ? fsm_mem_en_s   : flash_men;
  assign mem_we      = prog_mode ? fsm_mem_we_s   : |flash_mwe;
  assign mem_addr    = prog_mode ? fsm_mem_addr_s : flash_maddr[31:2];
  assign mem_din     = prog_mode ? fsm_mem_din_s  : flash_mdin;
  assign flash_mdout = mem_dout;
  assign in_rd_en    = in_rd_en_s;
  assign out_wr_en   = out_wr_en_s;
  assign out_din     = out_din_s;
  assign busy        = busy_r;
  assign done        = done_r;
  assign overflow    = overflow_r;
  assign word_count  = word_count_r;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader with an 8-word ROM, FWFT in-FIFO and out-FIFO models.
module tb_prog_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prog_mode, cmd_load, cmd_readback;
  logic        in_empty = 1'b1;
  logic [31:0] in_dout  = 32'h0;
  logic        in_rd_en;
  logic        out_full;
  logic [31:0] out_din;
  logic        out_wr_en;
  logic        flash_men;
  logic [31:0] flash_maddr, flash_mdin, flash_mdout;
  logic [3:0]  flash_mwe;
  logic        mem_en, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic        busy, done, overflow;
  logic [3:0]  word_count;

  logic [31:0] rom [16];
  logic [31:0] in_q [$];
  logic [31:0] out_q [$];
  int          wr_while_full = 0;
  int          checks = 0;
  int          failures = 0;
  int          snap;

  prog_mem_loader #(.DEPTH_WORDS(8)) dut (
    .CLK(clk), .RESETn(rst_n), .prog_mode(prog_mode), .cmd_load(cmd_load),
    .cmd_readback(cmd_readback), .in_empty(in_empty), .in_dout(in_dout),
    .in_rd_en(in_rd_en), .out_full(out_full), .out_din(out_din), .out_wr_en(out_wr_en),
    .flash_men(flash_men), .flash_maddr(flash_maddr), .flash_mdin(flash_mdin),
    .flash_mwe(flash_mwe), .flash_mdout(flash_mdout), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy),
    .done(done), .overflow(overflow), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // ROM with 1-cycle read latency, read-before-write.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) rom[mem_addr[3:0]] <= mem_din;
      mem_dout <= rom[mem_addr[3:0]];
    end
  end

  // FWFT pipe-in FIFO model.
  always @(posedge clk) begin
    if (in_rd_en && in_q.size() > 0) void'(in_q.pop_front());
    in_empty <= (in_q.size() == 0);
    in_dout  <= (in_q.size() > 0) ? in_q[0] : 32'h0;
  end

  // Pipe-out FIFO capture.
  always @(posedge clk) begin
    if (out_wr_en) begin
      out_q.push_back(out_din);
      if (out_full) wr_while_full++;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; prog_mode = 1'b0; cmd_load = 1'b0; cmd_readback = 1'b0;
    out_full = 1'b0; flash_men = 1'b0; flash_maddr = 32'h0; flash_mdin = 32'h0;
    flash_mwe = 4'h0;
    tick(3);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_overflow", {31'h0, overflow}, 32'h0);
    check("rst_word_count", {28'h0, word_count}, 32'h0);
    check("rst_in_rd_en", {31'h0, in_rd_en}, 32'h0);
    check("rst_out_wr_en", {31'h0, out_wr_en}, 32'h0);
    check("rst_out_din", out_din, 32'h0);
    rst_n = 1'b1;
    prog_mode = 1'b1;
    tick(1);

    // Load four words.
    for (int i = 0; i < 4; i++) in_q.push_back(32'hA0 + 32'(i));
    cmd_load = 1'b1;
    tick(1);
    check("load_busy", {31'h0, busy}, 32'h1);
    tick(6);
    check("load_count", {28'h0, word_count}, 32'd4);
    for (int i = 0; i < 4; i++) check("load_rom", rom[i], 32'hA0 + 32'(i));
    check("load_fifo_drained", 32'(in_q.size()), 32'd0);
    cmd_load = 1'b0;
    tick(1);
    check("load_done", {31'h0, done}, 32'h1);
    check("load_done_busy", {31'h0, busy}, 32'h0);
    prog_mode = 1'b0;
    tick(1);
    check("load_idle", {31'h0, done}, 32'h0);
    prog_mode = 1'b1;
    tick(1);

    // Overflow: ten words into an eight-word ROM.
    for (int i = 0; i < 10; i++) in_q.push_back(32'(i));
    cmd_load = 1'b1;
    tick(14);
    check("ovf_count", {28'h0, word_count}, 32'd8);
    check("ovf_flag", {31'h0, overflow}, 32'h1);
    check("ovf_popped_all", 32'(in_q.size()), 32'd0);
    check("ovf_rom0", rom[0], 32'h0);
    check("ovf_rom7", rom[7], 32'h7);
    cmd_load = 1'b0;
    tick(1);
    check("ovf_done", {31'h0, done}, 32'h1);
    prog_mode = 1'b0;
    tick(1);
    check("ovf_sticky_idle", {31'h0, overflow}, 32'h1);
    prog_mode = 1'b1;
    tick(1);

    // Readback with random backpressure.
    cmd_readback = 1'b1;
    for (int i = 0; i < 200; i++) begin
      out_full = 1'($urandom_range(0, 1));
      tick(1);
      if (done) break;
    end
    out_full = 1'b0;
    check("rb_done", {31'h0, done}, 32'h1);
    check("rb_count", 32'(out_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < out_q.size()) check("rb_data", out_q[i], 32'(i));
    end
    check("rb_no_write_when_full", 32'(wr_while_full), 32'd0);
    check("rb_word_count", {28'h0, word_count}, 32'd8);
    cmd_readback = 1'b0;
    prog_mode = 1'b0;
    tick(1);
    check("rb_idle", {30'h0, busy, done}, 32'h0);

    // Arbitration: core owns the port.
    flash_men = 1'b1; flash_maddr = 32'h10; flash_mwe = 4'h0;
    #1;
    check("arb_addr", {2'b00, mem_addr}, 32'd4);
    check("arb_we", {31'h0, mem_we}, 32'h0);
    check("arb_en", {31'h0, mem_en}, 32'h1);
    tick(1);
    check("arb_mdout", flash_mdout, 32'h4);
    flash_men = 1'b0; flash_mwe = 4'h3; flash_mdin = 32'hDEAD_BEEF;
    #1;
    check("arb_we_or", {31'h0, mem_we}, 32'h1);
    check("arb_din", mem_din, 32'hDEAD_BEEF);
    flash_mwe = 4'h0;

    // Abort readback at word 3.
    out_q.delete();
    prog_mode = 1'b1;
    tick(1);
    cmd_readback = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (word_count == 4'd3) break;
    end
    check("abort_reached3", {28'h0, word_count}, 32'd3);
    snap = out_q.size();
    prog_mode = 1'b0;
    tick(1);
    check("abort_idle_busy", {31'h0, busy}, 32'h0);
    check("abort_idle_done", {31'h0, done}, 32'h0);
    check("abort_count", {28'h0, word_count}, 32'h0);
    tick(4);
    check("abort_no_writes", 32'(out_q.size()), 32'(snap));
    cmd_readback = 1'b0;

    // Asynchronous reset in the middle of a load.
    prog_mode = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) in_q.push_back(32'h50 + 32'(i));
    cmd_load = 1'b1;
    tick(2);
    check("rstld_active", {31'h0, in_rd_en}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rstld_in_rd_en", {31'h0, in_rd_en}, 32'h0);
    check("rstld_mem_en", {31'h0, mem_en}, 32'h0);
    check("rstld_mem_we", {31'h0, mem_we}, 32'h0);
    check("rstld_busy", {31'h0, busy}, 32'h0);
    check("rstld_count", {28'h0, word_count}, 32'h0);
    check("rstld_out", {31'h0, out_wr_en}, 32'h0);
    check("rstld_out_din", out_din, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
